// File: rtl/sopc_be_input_conditioner_pkg.sv
// rtl/sopc_be_input_conditioner_pkg.sv - shared constants, state encoding and clog2 for the input conditioner
//
// Contents:
//   DEBOUNCE_CYCLES_DEFAULT  default stability window (1 ms at 50 MHz)
//   db_state_e               per-bit debounce FSM state (1 bit)
//   clog2()                  ceiling log2, used to size the per-bit counter
package sopc_be_input_conditioner_pkg;

    localparam int DEBOUNCE_CYCLES_DEFAULT = 50000;

    typedef enum logic {
        DB_IDLE     = 1'b0,
        DB_COUNTING = 1'b1
    } db_state_e;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/sopc_be_debounce_bit.sv
// rtl/sopc_be_debounce_bit.sv - two-flop synchronizer, stability counter and edge strobes for one input bit
//
// Ports:
//   clk            system clock
//   reset_n        asynchronous active-low reset
//   raw_in         asynchronous pad input
//   debounced_out  accepted (stable) level
//   rise_pulse     registered one-cycle strobe on an accepted 0->1
//   fall_pulse     registered one-cycle strobe on an accepted 1->0
//   change_next    high in the cycle before any strobe; lets the top register any_change alongside them
module sopc_be_debounce_bit
    import sopc_be_input_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw_in,
    output logic debounced_out,
    output logic rise_pulse,
    output logic fall_pulse,
    output logic change_next
);

    localparam int              CNT_W    = clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             s1;
    logic             s2;
    logic             stable;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    db_state_e        state;
    db_state_e        state_next;
    logic             mismatch;
    logic             accept;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= raw_in;
            s2 <= s1;
        end
    end

    assign mismatch = (s2 != stable);

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        accept     = 1'b0;
        case (state)
            DB_IDLE: begin
                // The edge that first sees the mismatch already counts as one
                // stable cycle, so the window closes exactly DEBOUNCE_CYCLES
                // mismatching s2 cycles after it opened.
                if (mismatch) begin
                    state_next = DB_COUNTING;
                    cnt_next   = CNT_ONE;
                end else begin
                    cnt_next   = '0;
                end
            end
            DB_COUNTING: begin
                if (!mismatch) begin
                    // A bounce throws away all accumulated progress.
                    state_next = DB_IDLE;
                    cnt_next   = '0;
                end else if (cnt == CNT_LAST) begin
                    accept     = 1'b1;
                    state_next = DB_IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next   = cnt + CNT_ONE;
                end
            end
            default: begin
                state_next = DB_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= DB_IDLE;
            cnt        <= '0;
            stable     <= 1'b0;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            if (accept) begin
                stable <= s2;
            end
            // Strobes update on the same edge as stable, so they line up
            // with the first cycle that shows the new level.
            rise_pulse <= accept & s2;
            fall_pulse <= accept & ~s2;
        end
    end

    assign debounced_out = stable;
    assign change_next   = accept;

endmodule

// File: rtl/sopc_be_input_conditioner.sv
// rtl/sopc_be_input_conditioner.sv - synchronizes and debounces WIDTH pad inputs for the SOPC GPIO input PIO
//
// Ports:
//   clk            system clock
//   reset_n        asynchronous active-low reset
//   raw_in         [WIDTH] asynchronous pad inputs, active-high
//   debounced_out  [WIDTH] conditioned levels for PIO in_port
//   rise_pulse     [WIDTH] one-cycle strobe per bit on an accepted 0->1
//   fall_pulse     [WIDTH] one-cycle strobe per bit on an accepted 1->0
//   any_change     OR of all strobes, registered in the same cycle as them
module sopc_be_input_conditioner
    import sopc_be_input_conditioner_pkg::*;
#(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] raw_in,
    output logic [WIDTH-1:0] debounced_out,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse,
    output logic             any_change
);

    logic [WIDTH-1:0] change_next;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        sopc_be_debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_bit (
            .clk           (clk),
            .reset_n       (reset_n),
            .raw_in        (raw_in[i]),
            .debounced_out (debounced_out[i]),
            .rise_pulse    (rise_pulse[i]),
            .fall_pulse    (fall_pulse[i]),
            .change_next   (change_next[i])
        );
    end

    // Registered from the per-bit accept terms rather than ORing the
    // strobe flops, so any_change is itself a flop output.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            any_change <= 1'b0;
        end else begin
            any_change <= |change_next;
        end
    end

endmodule

// File: tb/tb_sopc_be_input_conditioner.sv
// tb/tb_sopc_be_input_conditioner.sv - self-checking bench for sopc_be_input_conditioner
module tb_sopc_be_input_conditioner;

    localparam int W = 8;
    localparam int D = 4;

    logic         clk;
    logic         reset_n;
    logic [W-1:0] raw_in;
    logic [W-1:0] debounced_out;
    logic [W-1:0] rise_pulse;
    logic [W-1:0] fall_pulse;
    logic         any_change;

    int total = 0;
    int bad   = 0;

    // Reference: s2 is raw delayed two edges; a bit flips once the last D
    // s2 samples seen at clock edges all disagree with its current level.
    logic [W-1:0] m_s1, m_s2, m_stable, m_rise, m_fall;
    logic         m_any;
    logic [W-1:0] hist[$];
    int           rise3_cnt, rise5_cnt, fall5_cnt;

    sopc_be_input_conditioner #(
        .WIDTH           (W),
        .DEBOUNCE_CYCLES (D)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .raw_in        (raw_in),
        .debounced_out (debounced_out),
        .rise_pulse    (rise_pulse),
        .fall_pulse    (fall_pulse),
        .any_change    (any_change)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_stable = '0;
        m_rise = '0; m_fall = '0; m_any = 1'b0;
        hist.delete();
    endtask

    task automatic model_step(input logic [W-1:0] raw);
        logic [W-1:0] acc;
        bit           all_diff;
        acc = '0;
        hist.push_back(m_s2);
        if (hist.size() > D) hist.delete(0);
        if (hist.size() == D) begin
            for (int i = 0; i < W; i++) begin
                all_diff = 1'b1;
                for (int j = 0; j < D; j++)
                    if (hist[j][i] == m_stable[i]) all_diff = 1'b0;
                acc[i] = all_diff;
            end
        end
        m_rise   = acc & ~m_stable;
        m_fall   = acc & m_stable;
        m_stable = m_stable ^ acc;
        m_any    = |acc;
        m_s2     = m_s1;
        m_s1     = raw;
    endtask

    task automatic tick();
        model_step(raw_in);
        @(posedge clk);
        #1;
        chk("model_debounced", debounced_out, m_stable);
        chk("model_rise", rise_pulse, m_rise);
        chk("model_fall", fall_pulse, m_fall);
        chk("model_any", any_change, m_any);
        if (rise_pulse[3]) rise3_cnt++;
        if (rise_pulse[5]) rise5_cnt++;
        if (fall_pulse[5]) fall5_cnt++;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_debounced"}, debounced_out, 0);
        chk({tag, "_rise"}, rise_pulse, 0);
        chk({tag, "_fall"}, fall_pulse, 0);
        chk({tag, "_any"}, any_change, 0);
    endtask

    initial begin
        int hold;
        reset_n = 1'b0;
        raw_in  = 8'hFF;
        model_reset();
        rise3_cnt = 0; rise5_cnt = 0; fall5_cnt = 0;

        // Reset held with all inputs high, then release between edges.
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        reset_n = 1'b1;
        ticks(5);
        chk("reset_lat5_debounced", debounced_out, 8'h00);
        tick();
        chk("reset_lat6_debounced", debounced_out, 8'hFF);
        chk("reset_lat6_rise", rise_pulse, 8'hFF);
        chk("reset_lat6_any", any_change, 1);
        tick();
        chk("reset_rise_one_cycle", rise_pulse, 8'h00);
        chk("reset_any_one_cycle", any_change, 0);

        // Clean single-bit edge.
        raw_in = 8'h00;
        ticks(10);
        raw_in = 8'h01;
        ticks(5);
        chk("clean_lat5", debounced_out, 8'h00);
        tick();
        chk("clean_lat6", debounced_out, 8'h01);
        chk("clean_rise", rise_pulse, 8'h01);
        chk("clean_fall", fall_pulse, 8'h00);
        tick();
        chk("clean_rise_drop", rise_pulse, 8'h00);

        // Bounce on bit 3 at 3-cycle intervals, then held high.
        rise3_cnt = 0;
        for (int b = 0; b < 4; b++) begin
            raw_in = (b % 2 == 0) ? 8'h09 : 8'h01;
            ticks(3);
        end
        raw_in = 8'h09;
        ticks(5);
        chk("bounce_lat5", debounced_out[3], 0);
        tick();
        chk("bounce_lat6", debounced_out[3], 1);
        chk("bounce_rise", rise_pulse[3], 1);
        ticks(4);
        chk("bounce_single_rise", rise3_cnt, 1);

        // Short glitch on bit 5.
        rise5_cnt = 0; fall5_cnt = 0;
        raw_in = 8'h29;
        ticks(3);
        raw_in = 8'h09;
        ticks(8);
        chk("glitch_level", debounced_out[5], 0);
        chk("glitch_rises", rise5_cnt, 0);
        chk("glitch_falls", fall5_cnt, 0);

        // Simultaneous multi-bit change.
        raw_in = 8'h0F;
        ticks(10);
        chk("simul_pre", debounced_out, 8'h0F);
        raw_in = 8'hF0;
        ticks(5);
        chk("simul_lat5", debounced_out, 8'h0F);
        tick();
        chk("simul_lat6", debounced_out, 8'hF0);
        chk("simul_rise", rise_pulse, 8'hF0);
        chk("simul_fall", fall_pulse, 8'h0F);
        chk("simul_any", any_change, 1);

        // Reset while bit 1's counter is at 2.
        raw_in = 8'h00;
        ticks(10);
        raw_in = 8'h02;
        ticks(4);
        #1;
        reset_n = 1'b0;
        #1;
        chk_all_zero("midreset");
        model_reset();
        #1;
        reset_n = 1'b1;
        ticks(5);
        chk("midreset_lat5", debounced_out, 8'h00);
        tick();
        chk("midreset_lat6", debounced_out, 8'h02);
        chk("midreset_rise", rise_pulse, 8'h02);

        // Random bursts with mixed hold lengths, checked against the model.
        hold = 0;
        for (int n = 0; n < 600; n++) begin
            if (hold == 0) begin
                raw_in = raw_in ^ 8'($urandom_range(0, 255));
                hold   = $urandom_range(1, 7);
            end
            hold--;
            tick();
        end
        ticks(10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
